matrix_mult_engine: RTL and testbench

Parametrised successor to the single-matrix accelerator. It holds matrices A, B and C in inferred block RAMs of configurable dimension and data width. Load ports fill A and B; a sequencer then computes C = A × B using one signed multiply-accumulate per cycle; C is read back through a streaming port. It sits between the PS-side register/stream bridge and the matrix RAMs, replacing the fixed 64×64, A-only datapath.

---
 rtl/matrix_mult_engine.sv | 211 +++++++++++++++++++++
 tb/tb_matrix_mult_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mult_engine.sv
// matrix_mult_engine: C = A x B over inferred RAMs, one signed MAC per cycle.
// Define MACC_SATURATE_EN to saturate C to OW bits instead of wrapping.
module matrix_mult_engine #(
    parameter int DIM = 8,
    parameter int DW  = 16,
    parameter int OW  = 32
) (
    input  logic          CLK,
    input  logic          RST_L,
    input  logic [1:0]    wen,
    input  logic [DW-1:0] matrix_a_in,
    input  logic [DW-1:0] matrix_b_in,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          ren,
    output logic [OW-1:0] matrix_c_out,
    output logic          c_valid
);
    localparam int LD    = $clog2(DIM);
    localparam int AW    = 2 * LD;
    localparam int NE    = DIM * DIM;
    localparam int ACC_W = 2 * DW + LD;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state;

    logic [DW-1:0] a_ram [NE];
    logic [DW-1:0] b_ram [NE];
    logic [OW-1:0] c_ram [NE];

    logic [AW-1:0] a_ptr, b_ptr, c_ptr;
    logic [LD-1:0] i_idx, j_idx, k_idx;
    logic [1:0]    drain_cnt;

    logic          s1_v, s1_k0, s1_kl;
    logic [AW-1:0] s1_addr;
    logic [DW-1:0] a_rd, b_rd;

    logic                    s2_v, s2_k0, s2_kl;
    logic [AW-1:0]           s2_addr;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;

    logic          s3_wr;
    logic [AW-1:0] s3_addr;
    logic [OW-1:0] c_wdata;

    logic idle, a_we, b_we, c_re, issue, last;

    assign idle  = (state == IDLE);
    assign a_we  = idle & wen[1];
    assign b_we  = idle & wen[0];
    assign c_re  = idle & ren;
    assign issue = (state == RUN);
    assign last  = (&i_idx) & (&j_idx) & (&k_idx);

    assign prod_ext = {{LD{prod[2*DW-1]}}, prod};

`ifdef MACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] C_MAX =
        {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN =
        {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

    always_comb begin
        c_wdata = acc[OW-1:0];
        if (acc > C_MAX)
            c_wdata = C_MAX[OW-1:0];
        else if (acc < C_MIN)
            c_wdata = C_MIN[OW-1:0];
    end
`else
    assign c_wdata = acc[OW-1:0];

    generate
        if (OW < ACC_W) begin : g_drop
            logic unused_acc_hi;
            assign unused_acc_hi = ^acc[ACC_W-1:OW];
        end
    endgenerate
`endif

    // Operand RAMs: load port in IDLE, row-major operand fetch in RUN
    always_ff @(posedge CLK) begin
        if (a_we)
            a_ram[a_ptr] <= matrix_a_in;
        if (issue)
            a_rd <= a_ram[{i_idx, k_idx}];
    end

    always_ff @(posedge CLK) begin
        if (b_we)
            b_ram[b_ptr] <= matrix_b_in;
        if (issue)
            b_rd <= b_ram[{k_idx, j_idx}];
    end

    always_ff @(posedge CLK) begin
        if (s3_wr)
            c_ram[s3_addr] <= c_wdata;
    end

    always_ff @(posedge CLK) begin
        if (!RST_L)
            matrix_c_out <= '0;
        else if (c_re)
            matrix_c_out <= c_ram[c_ptr];
    end

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            c_valid   <= 1'b0;
            a_ptr     <= '0;
            b_ptr     <= '0;
            c_ptr     <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            k_idx     <= '0;
            drain_cnt <= '0;
            s1_v      <= 1'b0;
            s1_k0     <= 1'b0;
            s1_kl     <= 1'b0;
            s1_addr   <= '0;
            s2_v      <= 1'b0;
            s2_k0     <= 1'b0;
            s2_kl     <= 1'b0;
            s2_addr   <= '0;
            prod      <= '0;
            acc       <= '0;
            s3_wr     <= 1'b0;
            s3_addr   <= '0;
        end else begin
            done    <= 1'b0;
            c_valid <= c_re;

            s1_v    <= issue;
            s1_k0   <= (k_idx == '0);
            s1_kl   <= &k_idx;
            s1_addr <= {i_idx, j_idx};

            s2_v    <= s1_v;
            s2_k0   <= s1_k0;
            s2_kl   <= s1_kl;
            s2_addr <= s1_addr;
            prod    <= $signed(a_rd) * $signed(b_rd);

            // Load on k=0 so each dot product starts clean
            if (s2_v)
                acc <= s2_k0 ? prod_ext : acc + prod_ext;
            s3_wr   <= s2_v & s2_kl;
            s3_addr <= s2_addr;

            if (c_re)
                c_ptr <= c_ptr + 1'b1;

            unique case (state)
                IDLE: begin
                    if (a_we)
                        a_ptr <= a_ptr + 1'b1;
                    if (b_we)
                        b_ptr <= b_ptr + 1'b1;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a_ptr <= '0;
                        b_ptr <= '0;
                        c_ptr <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        k_idx <= '0;
                    end
                end
                RUN: begin
                    k_idx <= k_idx + 1'b1;
                    if (&k_idx) begin
                        j_idx <= j_idx + 1'b1;
                        if (&j_idx)
                            i_idx <= i_idx + 1'b1;
                    end
                    if (last) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    // Three edges: product, accumulate, final C write
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == 2'd2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        a_ptr <= '0;
                        b_ptr <= '0;
                        c_ptr <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_engine.sv
// Directed bench for matrix_mult_engine: a DIM=2/DW=8/OW=8 instance and a
// DIM=4/DW=16/OW=32 instance sharing stimulus, selected by sel.
module tb_matrix_mult_engine;
    logic        clk = 1'b0;
    logic        rst_l;
    logic [1:0]  wen;
    logic [15:0] a_in, b_in;
    logic        start, ren, sel;

    logic        busy2, done2, cv2;
    logic [7:0]  c2;
    logic        busy4, done4, cv4;
    logic [31:0] c4;

    logic        busy, done, c_valid;
    logic [31:0] c_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_mult_engine #(.DIM(2), .DW(8), .OW(8)) u_small (
        .CLK          (clk),
        .RST_L        (rst_l),
        .wen          (sel ? 2'b00 : wen),
        .matrix_a_in  (a_in[7:0]),
        .matrix_b_in  (b_in[7:0]),
        .start        (start & ~sel),
        .busy         (busy2),
        .done         (done2),
        .ren          (ren & ~sel),
        .matrix_c_out (c2),
        .c_valid      (cv2)
    );

    matrix_mult_engine #(.DIM(4), .DW(16), .OW(32)) u_big (
        .CLK          (clk),
        .RST_L        (rst_l),
        .wen          (sel ? wen : 2'b00),
        .matrix_a_in  (a_in),
        .matrix_b_in  (b_in),
        .start        (start & sel),
        .busy         (busy4),
        .done         (done4),
        .ren          (ren & sel),
        .matrix_c_out (c4),
        .c_valid      (cv4)
    );

    assign busy    = sel ? busy4 : busy2;
    assign done    = sel ? done4 : done2;
    assign c_valid = sel ? cv4 : cv2;
    assign c_out   = sel ? c4 : {24'h0, c2};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] w, input logic [15:0] a,
                        input logic [15:0] b);
        wen  = w;
        a_in = a;
        b_in = b;
        tick();
        wen  = 2'b00;
    endtask

    task automatic run(input int exp_lat);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        chk("busy_t0p1", busy, 1);
        while (!done && lat < 200) begin
            chk("cvalid_busy", c_valid, 0);
            tick();
            lat++;
        end
        chk("done_latency", lat, exp_lat);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic rd(input string tag, input logic [31:0] exp);
        ren = 1'b1;
        tick();
        chk({tag, "_valid"}, c_valid, 1);
        chk(tag, c_out, exp);
    endtask

    task automatic rd4(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
        rd("c00", e0);
        rd("c01", e1);
        rd("c10", e2);
        rd("c11", e3);
        ren = 1'b0;
        tick();
        chk("cvalid_idle", c_valid, 0);
        chk("c_hold", c_out, e3);
    endtask

    task automatic load_ab(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3,
                           input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3);
        load(2'b11, a0, b0);
        load(2'b11, a1, b1);
        load(2'b11, a2, b2);
        load(2'b11, a3, b3);
    endtask

    initial begin
        int lat;
        int ndone;
        logic [31:0] sat_exp;

`ifdef MACC_SATURATE_EN
        sat_exp = 32'd127;
`else
        sat_exp = 32'd2;
`endif
        rst_l = 1'b0;
        wen   = 2'b00;
        a_in  = '0;
        b_in  = '0;
        start = 1'b0;
        ren   = 1'b0;
        sel   = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_busy_s", busy, 0);
        chk("rst_done_s", done, 0);
        chk("rst_cv_s", c_valid, 0);
        chk("rst_c_s", c_out, 0);
        sel = 1'b1;
        #1;
        chk("rst_busy_b", busy, 0);
        chk("rst_cv_b", c_valid, 0);
        chk("rst_c_b", c_out, 0);
        sel = 1'b0;
        rst_l = 1'b1;
        tick();

        // Basic 2x2 product
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        run(12);
        rd4(19, 22, 43, 50);

        // start retrigger and wen/ren while busy must be ignored
        start = 1'b1;
        tick();
        lat = 1;
        while (!done && lat < 200) begin
            start = (lat == 3);
            wen   = (lat < 10) ? 2'b11 : 2'b00;
            ren   = (lat < 10);
            a_in  = 16'd99;
            b_in  = 16'd99;
            chk("cvalid_busy2", c_valid, 0);
            tick();
            lat++;
        end
        start = 1'b0;
        wen   = 2'b00;
        ren   = 1'b0;
        chk("retrig_latency", lat, 12);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done)
                ndone++;
        end
        chk("retrig_no_2nd_done", ndone, 0);
        rd4(19, 22, 43, 50);
        run(12);
        rd4(19, 22, 43, 50);

        // Overflow of OW=8 output: saturate or wrap
        load_ab(127, 127, 127, 127, 127, 127, 127, 127);
        run(12);
        rd4(sat_exp, sat_exp, sat_exp, sat_exp);

        // Fifth A write wraps onto A[0]
        load_ab(1, 2, 3, 4, 5, 6, 7, 8);
        load(2'b10, 2, 0);
        run(12);
        rd4(24, 28, 43, 50);

        // Reset in the middle of a compute
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++)
            tick();
        rst_l = 1'b0;
        tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        rst_l = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done)
                ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        run(12);
        rd4(24, 28, 43, 50);

        // DIM=4: identity x ramp, then wrap of the read pointer
        sel = 1'b1;
        #1;
        for (int n = 0; n < 16; n++)
            load(2'b11, ((n / 4) == (n % 4)) ? 16'd1 : 16'd0, 16'(n));
        run(68);
        for (int n = 0; n < 16; n++)
            rd($sformatf("big_c%0d", n), 32'(n));
        rd("big_wrap", 0);
        ren = 1'b0;
        tick();
        chk("big_cv_idle", c_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
